// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core front end and decoder.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Sign-extended word offset of a branch immediate, in bytes
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{(XLEN-18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (bubble insert) beats stall (hold).
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush_i,
    input  logic  stall_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next IF/ID contents: bubble, hold, or load the fetched word
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (!stall_i) begin
            ifid_d = d_i;
        end
    end

    // IF/ID state, cleared to a bubble on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select, IF/ID register and perf counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XLEN-1:0]  InstrF,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenD,
    input  logic             JumpD,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  InstrD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic [XLEN-1:0]  pc_plus4_f;
    logic [XLEN-1:0]  branch_target_d;
    logic [XLEN-1:0]  jump_target_d;
    logic             redir_d;
    logic             squash_d;
    logic             load_d;
    ifid_t            ifid_in;
    ifid_t            ifid_out;

    // Sequential fetch address and decode-stage redirect targets
    always_comb begin
        pc_plus4_f      = pc_q + XLEN'(WORD_BYTES);
        branch_target_d = ifid_out.pc_plus4 + branch_offset(ifid_out.instr[15:0]);
        jump_target_d   = {ifid_out.pc_plus4[31:28], ifid_out.instr[25:0], 2'b00};
        // A stalled decode or a bubble cannot redirect fetch
        redir_d         = (BranchTakenD | JumpD) & ifid_out.valid & ~StallD;
        squash_d        = FlushD | redir_d;
        load_d          = ~squash_d & ~StallD;
    end

    // Next-PC select: stall, then jump, then branch, then sequential
    always_comb begin
        pc_d = pc_plus4_f;
        if (StallF) begin
            pc_d = pc_q;
        end else if (redir_d && JumpD) begin
            pc_d = jump_target_d;
        end else if (redir_d && BranchTakenD) begin
            pc_d = branch_target_d;
        end
    end

    // Performance counters, wrapping silently
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_d) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
        if (squash_d) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // PC and counter state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ifid_in = '{instr: InstrF, pc_plus4: pc_plus4_f, valid: 1'b1};

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (CLK),
        .rst     (RST),
        .flush_i (squash_d),
        .stall_i (StallD),
        .d_i     (ifid_in),
        .q_o     (ifid_out)
    );

    assign PCF        = pc_q;
    assign InstrD     = ifid_out.instr;
    assign PCPlus4D   = ifid_out.pc_plus4;
    assign ValidD     = ifid_out.valid;
    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/flush/redirect.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] InstrF;
    logic        StallF, StallD, FlushD, BranchTakenD, JumpD;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount, FlushCount;

    bit          walk_en;
    logic [31:0] walk_goal;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4d, m_fc, m_flc;
    bit          m_valid;

    int vectors;
    int miscompares;

    fetch_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .InstrF       (InstrF),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenD (BranchTakenD),
        .JumpD        (JumpD),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD),
        .FetchCount   (FetchCount),
        .FlushCount   (FlushCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory image; in walk mode every word is a beq stepping toward goal
    function automatic logic [31:0] imem(input logic [31:0] a, input bit walk, input logic [31:0] goal);
        logic [31:0] words;
        if (walk && a != goal) begin
            words = (goal - (a + 32'd4)) >> 2;
            if (words > 32'h0000_7FFF) words = 32'h0000_7FFF;
            return 32'h1000_0000 | words;
        end
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0007;
            32'h0000_000C: return 32'h1109_0003;
            32'h0000_0020: return 32'h1000_FFF6;
            32'h1000_0000: return 32'h0800_0040;
            32'h1000_0100: return 32'h0800_0040;
            default:       return {a[15:0] ^ 16'hA5C3, a[31:16] + a[15:0]};
        endcase
    endfunction

    assign InstrF = imem(PCF, walk_en, walk_goal);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PCF"},        PCF,          m_pc);
        check({tag, ".InstrD"},     InstrD,       m_instr);
        check({tag, ".PCPlus4D"},   PCPlus4D,     m_pc4d);
        check({tag, ".ValidD"},     32'(ValidD),  32'(m_valid));
        check({tag, ".FetchCount"}, FetchCount,   m_fc);
        check({tag, ".FlushCount"}, FlushCount,   m_flc);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4d  = 32'h0;
        m_valid = 1'b0;
        m_fc    = 32'h0;
        m_flc   = 32'h0;
    endtask

    // One clock of stimulus; model advances by the fetch rules, then DUT is compared
    task automatic step(input bit stf, input bit std, input bit fl, input bit bt, input bit jd, input string tag);
        logic [31:0] fetched;
        logic [31:0] npc;
        bit          redir;
        int          off;
        StallF       = stf;
        StallD       = std;
        FlushD       = fl;
        BranchTakenD = bt;
        JumpD        = jd;
        fetched = imem(m_pc, walk_en, walk_goal);
        redir   = (bt || jd) && m_valid && !std;
        off     = int'($signed(m_instr[15:0])) * 4;
        if (stf)                npc = m_pc;
        else if (redir && jd)   npc = {m_pc4d[31:28], m_instr[25:0], 2'b00};
        else if (redir && bt)   npc = m_pc4d + 32'(off);
        else                    npc = m_pc + 32'd4;
        if (fl || redir) begin
            m_instr = 32'h0;
            m_pc4d  = 32'h0;
            m_valid = 1'b0;
            m_flc   = m_flc + 32'd1;
        end else if (!std) begin
            m_instr = fetched;
            m_pc4d  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_fc    = m_fc + 32'd1;
        end
        m_pc = npc;
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    // Reset pulse entirely between clock edges
    task automatic async_reset(input string tag);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 RST = 1'b0;
    endtask

    initial begin
        int guard;
        int r;
        vectors      = 0;
        miscompares  = 0;
        walk_en      = 1'b0;
        walk_goal    = 32'h1000_0000;
        RST          = 1'b1;
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        BranchTakenD = 1'b0;
        JumpD        = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        #2 RST = 1'b0;

        // Sequential fetch after reset
        step(0, 0, 0, 0, 0, "seq0");
        check("seq0.instr_first", InstrD, 32'h2008_0005);
        check("seq0.valid_first", 32'(ValidD), 32'd1);
        step(0, 0, 0, 0, 0, "seq1");
        check("seq1.pc8", PCF, 32'h0000_0008);
        check("seq1.fetch2", FetchCount, 32'd2);

        // Paired stall holds everything
        repeat (3) step(1, 1, 0, 0, 0, "stall");
        check("stall.pc_held", PCF, 32'h0000_0008);
        check("stall.fetch_held", FetchCount, 32'd2);
        step(0, 0, 0, 0, 0, "resume0");
        step(0, 0, 0, 0, 0, "resume1");
        check("beq.instr", InstrD, 32'h1109_0003);
        check("beq.pc4d", PCPlus4D, 32'h0000_0010);

        // Taken beq
        step(0, 0, 0, 1, 0, "beq");
        check("beq.target", PCF, 32'h0000_001C);
        check("beq.bubble", 32'(ValidD), 32'd0);
        check("beq.flushcnt", FlushCount, 32'd1);

        // Redirect ignored under StallD; flush beats stall
        step(0, 0, 0, 0, 0, "pre_stall_redir");
        step(0, 1, 0, 1, 0, "stalled_redir");
        check("stalled_redir.pc", PCF, 32'h0000_0024);
        check("stalled_redir.valid", 32'(ValidD), 32'd1);
        step(0, 1, 1, 0, 0, "flush_stall");
        check("flush_stall.valid", 32'(ValidD), 32'd0);

        // Async reset at PC 0x40
        guard = 0;
        while (m_pc != 32'h0000_0040 && guard < 32) begin
            step(0, 0, 0, 0, 0, "to40");
            guard++;
        end
        check("to40.pc", PCF, 32'h0000_0040);
        async_reset("async_rst");
        check("async_rst.pc", PCF, 32'h0000_0000);
        check("async_rst.instr", InstrD, 32'h0000_0000);

        // Backward branch to 0xFFFF_FFFC, then wrap to 0
        guard = 0;
        while (!(m_valid && m_instr == 32'h1000_FFF6) && guard < 32) begin
            step(0, 0, 0, 0, 0, "to_wrap_br");
            guard++;
        end
        step(0, 0, 0, 1, 0, "wrap_br");
        check("wrap_br.pc", PCF, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, "wrap");
        check("wrap.pc", PCF, 32'h0000_0000);

        // Chain of taken branches up to 0x1000_0000
        async_reset("walk_rst");
        walk_en = 1'b1;
        guard = 0;
        while (m_pc != walk_goal && guard < 6000) begin
            step(0, 0, 0, m_valid && (m_instr[31:26] == 6'h04), 0, "walk");
            guard++;
        end
        check("walk.reached", PCF, walk_goal);
        walk_en = 1'b0;

        // Jump, then jump with branch taken together
        step(0, 0, 0, 0, 0, "pre_jump");
        check("pre_jump.instr", InstrD, 32'h0800_0040);
        check("pre_jump.pc4d", PCPlus4D, 32'h1000_0004);
        step(0, 0, 0, 0, 1, "jump");
        check("jump.target", PCF, 32'h1000_0100);
        step(0, 0, 0, 0, 0, "pre_jump_br");
        step(0, 0, 0, 1, 1, "jump_br");
        check("jump_br.target", PCF, 32'h1000_0100);

        // Random stall/flush/redirect traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
            end else begin
                step((r < 3), (r < 2) || (r == 3),
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the pipelined MIPS core. Drives the instruction-memory address and latches the fetched word into the decode stage, where the instruction decoder consumes InstrD.
- Owns the PC and the PC-select mux: sequential PC+4, taken-branch target or jump target. Target arithmetic is done locally from the decode-stage instruction.
- Applies stall/flush from the hazard unit and keeps two free-running performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word inserted into InstrD on flush/reset (sll $0,$0,0).
- CNT_W, 32, width of performance counters.

Ports:
- CLK  input  1  core clock, all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- InstrF  input  32  instruction word read combinationally from imem at PCF
- StallF  input  1  hold PC
- StallD  input  1  hold IF/ID register
- FlushD  input  1  load IF/ID with NOP
- BranchTakenD  input  1  beq in decode resolved taken (Branch & equal)
- JumpD  input  1  jump decoded in decode stage
- PCF  output  32  imem address / current fetch PC
- InstrD  output  32  instruction to decode
- PCPlus4D  output  32  PC+4 of the instruction in decode
- ValidD  output  1  InstrD holds a real fetched instruction
- FetchCount  output  CNT_W  number of instructions accepted into IF/ID
- FlushCount  output  CNT_W  number of IF/ID flushes

Behaviour:
- Reset (async, any cycle, including mid-stall or mid-redirect): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, FetchCount=0, FlushCount=0. The first fetch uses RESET_PC in the cycle after RST deasserts.
- PCPlus4F = PCF+4, mod 2^32; wrap from 32'hFFFF_FFFC goes to 0.
- BranchTargetD = PCPlus4D + (sign_extend(InstrD[15:0]) << 2), mod 2^32.
- JumpTargetD = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- Redirect accepted (RedirD) = (BranchTakenD | JumpD) & ValidD & ~StallD. Redirects are ignored while decode is stalled or holding a bubble.
- Next-PC priority, highest first:
  - StallF=1: hold PCF.
  - JumpD accepted: JumpTargetD.
  - Branch accepted: BranchTargetD.
  - Otherwise: PCPlus4F.
  - If JumpD and BranchTakenD are both asserted, the jump wins.
- IF/ID register update priority, highest first:
  - FlushD=1 or RedirD=1: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0. The wrong-path fetch is squashed automatically on a redirect.
  - StallD=1: hold all IF/ID state.
  - Otherwise: InstrD=InstrF, PCPlus4D=PCPlus4F, ValidD=1.
  - FlushD beats StallD when both are asserted.
- Single-cycle fetch latency: the word at PCF appears on InstrD after one rising edge. Taken branch/jump penalty is exactly 1 bubble.
- StallF=1 with StallD=0 is legal. IF/ID then reloads the same InstrF each cycle and FetchCount still increments per load; the hazard unit never issues this pairing.
- FetchCount increments on every IF/ID load of a real instruction (third case above). FlushCount increments on every cycle in which the flush case applies. Both wrap silently at 2^CNT_W.
- PCF is driven directly from the PC register; no combinational path from the stall/flush inputs to PCF.

Decomposition:
- Shared package (mips_pkg): NOP_INSTR, RESET_PC default, opcode localparams (rType 6'h00, jump 6'h02, beq 6'h04), word-size constant 4. The instruction decoder uses the same package.
- One natural sub-module, if_id_reg: holds InstrD, PCPlus4D and ValidD, with the flush-over-stall priority.
- PC register, next-PC mux and counters stay in fetch_stage.

Test Plan:
- Reset release, imem returning 32'h2008_0005 at 0, 32'h2009_0007 at 4, no stalls → PCF goes 0,4,8. InstrD=32'h2008_0005 with ValidD=1 one cycle after PCF=0. FetchCount=2 after two loads.
- Stall pair: StallF=StallD=1 for 3 cycles while PCF=8 → PCF, InstrD, PCPlus4D unchanged. FetchCount unchanged. Fetch resumes at 8.
- Taken beq: InstrD=32'h1109_0003, PCPlus4D=32'h0000_0010, BranchTakenD=1 → next PCF=32'h0000_001C. InstrD=NOP, ValidD=0, FlushCount+1.
- Jump: InstrD=32'h0800_0040, PCPlus4D=32'h1000_0004, JumpD=1 → PCF=32'h1000_0100. Same cycle with BranchTakenD=1 → still 32'h1000_0100.
- Redirect during StallD=1, and FlushD with StallD both 1 →
  - Stalled redirect is ignored: PC advances per StallF.
  - FlushD with StallD: flush wins, ValidD=0.
- Async reset: RST pulse between edges while PCF=32'h0000_0040 → PCF=RESET_PC and InstrD=NOP immediately, without waiting for CLK. PC wrap check: PCF=32'hFFFF_FFFC with no stall → next PCF=0.
